// File: rtl/serializer.sv
// Parallel-to-serial converter: LENGTH-bit word in over valid/ready, one bit out per enabled clock.
// Bit order is LSB first; define SERIALIZER_MSB_FIRST_EN to emit MSB first instead.
module serializer #(
    parameter int unsigned LENGTH = 24
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_load_valid,
    input  logic [LENGTH-1:0] iv_din,
    output logic              o_load_ready,
    output logic              o_dout,
    output logic              o_dout_valid,
    output logic              o_busy
);

    localparam int unsigned    CW   = (LENGTH > 1) ? $clog2(LENGTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(LENGTH - 1);
`ifdef SERIALIZER_MSB_FIRST_EN
    localparam int unsigned    OUT_BIT = LENGTH - 1;
`else
    localparam int unsigned    OUT_BIT = 0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [LENGTH-1:0] shreg, shreg_nxt;
    logic [CW-1:0]     count, count_nxt;
    logic              dout_nxt, dout_valid_nxt, busy_nxt;
    logic              at_last;
    logic              can_load;

    assign at_last  = (state == SHIFT) && (count == LAST);
    assign can_load = i_load_valid && ((state == IDLE) || at_last);

    // State register and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state        <= IDLE;
            shreg        <= '0;
            count        <= '0;
            o_dout       <= 1'b0;
            o_dout_valid <= 1'b0;
            o_busy       <= 1'b0;
        end else begin
            state        <= state_nxt;
            shreg        <= shreg_nxt;
            count        <= count_nxt;
            o_dout       <= dout_nxt;
            o_dout_valid <= dout_valid_nxt;
            o_busy       <= busy_nxt;
        end
    end

    // Next state; outputs are precomputed from the next state so they register alongside it
    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        count_nxt      = count;
        dout_nxt       = o_dout;
        dout_valid_nxt = o_dout_valid;
        busy_nxt       = o_busy;
        if (i_en) begin
            if (can_load) begin
                state_nxt = SHIFT;
                shreg_nxt = iv_din;
                count_nxt = '0;
            end else if (state == SHIFT && !at_last) begin
`ifdef SERIALIZER_MSB_FIRST_EN
                shreg_nxt = {shreg[LENGTH-2:0], 1'b0};
`else
                shreg_nxt = {1'b0, shreg[LENGTH-1:1]};
`endif
                count_nxt = count + CW'(1);
            end else if (state == SHIFT) begin
                state_nxt = IDLE;
                shreg_nxt = '0;
                count_nxt = '0;
            end
            busy_nxt       = (state_nxt == SHIFT);
            dout_nxt       = (state_nxt == SHIFT) && shreg_nxt[OUT_BIT];
            dout_valid_nxt = (state_nxt == SHIFT) && (count_nxt == LAST);
        end
    end

    // Ready is deliberately not gated by i_en
    always_comb begin
        o_load_ready = 1'b0;
        if (state == IDLE || at_last) begin
            o_load_ready = 1'b1;
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Directed and random checks of serializer against a bit-stream model built from the loaded words.
// Honours SERIALIZER_MSB_FIRST_EN for the expected bit order.
module tb_serializer;

    localparam int LENGTH = 24;

    logic              tb_clk = 1'b0;
    logic              rst;
    logic              en;
    logic              load_valid;
    logic [LENGTH-1:0] din;
    logic              load_ready;
    logic              dout;
    logic              dout_valid;
    logic              busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 tb_clk = ~tb_clk;

    serializer #(.LENGTH(LENGTH)) dut (
        .i_clk        (tb_clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_load_valid (load_valid),
        .iv_din       (din),
        .o_load_ready (load_ready),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .o_busy       (busy)
    );

    // Which word bit is on the wire during the i-th bit slot
    function automatic int bitpos(int i);
`ifdef SERIALIZER_MSB_FIRST_EN
        return LENGTH - 1 - i;
`else
        return i;
`endif
    endfunction

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic chk_out(string tag, logic e_dout, logic e_valid, logic e_busy, logic e_ready);
        logic [3:0] obs;
        logic [3:0] exp;
        obs = {dout, dout_valid, busy, load_ready};
        exp = {e_dout, e_valid, e_busy, e_ready};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: {dout,valid,busy,ready} observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(string tag, logic [LENGTH-1:0] obs, logic [LENGTH-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(string tag, int obs, int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One load edge, then scramble din to prove it is only sampled at the load
    task automatic load(logic [LENGTH-1:0] w);
        load_valid = 1'b1;
        din        = w;
        tick();
        load_valid = 1'b0;
        din        = LENGTH'($urandom);
    endtask

    // Expects the first bit of w already on the wire; checks the whole word and the return to idle
    task automatic check_word(string tag, logic [LENGTH-1:0] w);
        for (int i = 0; i < LENGTH; i++) begin
            chk_out($sformatf("%s bit%0d", tag, i), w[bitpos(i)], i == LENGTH - 1, 1'b1, i == LENGTH - 1);
            tick();
        end
        chk_out({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [LENGTH-1:0] w;
        logic [LENGTH-1:0] w2;
        logic [LENGTH-1:0] exp_q[$];
        logic [LENGTH-1:0] hist;
        logic [LENGTH-1:0] expw;
        int sent;
        int rcvd;
        int cyc;

        // Reset, with a pending load that reset must override
        rst        = 1'b0;
        en         = 1'b1;
        load_valid = 1'b1;
        din        = 24'hDEADBE;
        repeat (3) begin
            tick();
            chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        end
        rst        = 1'b1;
        load_valid = 1'b0;
        repeat (3) begin
            tick();
            chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Single word
        load(24'hA5C3F0);
        check_word("single", 24'hA5C3F0);

        // Back-to-back words with load_valid held high
        w          = 24'h000001;
        w2         = 24'h800000;
        chk_out("b2b load cycle", 1'b0, 1'b0, 1'b0, 1'b1);
        load_valid = 1'b1;
        din        = w;
        tick();
        din        = w2;
        for (int j = 0; j < 2 * LENGTH; j++) begin
            chk_out($sformatf("b2b bit%0d", j),
                    (j < LENGTH) ? w[bitpos(j)] : w2[bitpos(j - LENGTH)],
                    (j == LENGTH - 1) || (j == 2 * LENGTH - 1), 1'b1,
                    (j == LENGTH - 1) || (j == 2 * LENGTH - 1));
            if (j == LENGTH) load_valid = 1'b0;
            tick();
        end
        chk_out("b2b idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Enable stalls mid-word and on the last bit (with a load offered while stalled)
        w = 24'hFFF000;
        load(w);
        for (int i = 0; i < LENGTH; i++) begin
            chk_out($sformatf("stall bit%0d", i), w[bitpos(i)], i == LENGTH - 1, 1'b1, i == LENGTH - 1);
            if (i == 10) begin
                en = 1'b0;
                repeat (5) begin
                    tick();
                    chk_out("stall hold", w[bitpos(10)], 1'b0, 1'b1, 1'b0);
                end
                en = 1'b1;
            end
            if (i == LENGTH - 1) begin
                en         = 1'b0;
                load_valid = 1'b1;
                repeat (2) begin
                    tick();
                    chk_out("stall last hold", w[bitpos(LENGTH - 1)], 1'b1, 1'b1, 1'b1);
                end
                load_valid = 1'b0;
                en         = 1'b1;
            end
            tick();
        end
        chk_out("stall idle", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a word, then a clean word
        w = 24'h123456;
        load(w);
        for (int i = 0; i <= 7; i++) begin
            chk_out($sformatf("midrst bit%0d", i), w[bitpos(i)], 1'b0, 1'b1, 1'b0);
            if (i < 7) tick();
        end
        rst = 1'b0;
        tick();
        chk_out("midrst after", 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        load(24'h654321);
        check_word("post rst", 24'h654321);

        // Random loopback through a receiver model that keeps the last LENGTH bits
        hist = '0;
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while (rcvd < 100 && cyc < 10000) begin
`ifdef SERIALIZER_MSB_FIRST_EN
            hist = {hist[LENGTH-2:0], dout};
`else
            hist = {dout, hist[LENGTH-1:1]};
`endif
            if (dout_valid) begin
                expw = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
                chk_word($sformatf("loop word%0d", rcvd), hist, expw);
                rcvd++;
            end
            din = LENGTH'($urandom);
            if (sent < 100 && $urandom_range(3) != 0) begin
                load_valid = 1'b1;
                if (load_ready) begin
                    exp_q.push_back(din);
                    sent++;
                end
            end else begin
                load_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        load_valid = 1'b0;
        chk_int("loop words received", rcvd, 100);
        chk_int("loop leftover", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter: accepts a LENGTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock, LSB first.
- Raises o_dout_valid coincident with the last bit of each word, the framing the team's deserializer consumes, so o_dout/o_dout_valid connect directly to its i_din/i_din_valid.
- Supports gapless back-to-back words.

Parameters:
- LENGTH, 24, word width in bits; legal range 2..64.

Ports:
- i_clk  input  1  clock; all logic on the rising edge.
- i_rst  input  1  synchronous, active-low reset; sampled on the rising edge of i_clk.
- i_en  input  1  clock enable; when 0 all state holds, including outputs.
- i_load_valid  input  1  iv_din holds a word to transmit.
- iv_din  input  LENGTH  parallel word to transmit.
- o_load_ready  output  1  serializer can accept a word this cycle (combinational from state).
- o_dout  output  1  serial data bit, registered.
- o_dout_valid  output  1  high exactly during the last bit of a word, registered.
- o_busy  output  1  high while in SHIFT.

Behaviour:
- Reset (i_rst=0 at an edge): state=IDLE, shift register=0, bit counter=0, o_dout=0, o_dout_valid=0, o_busy=0. Reset wins over i_en and load.
- Reset mid-word: the word is abandoned, with no partial flush. o_load_ready=1 from the next cycle.
- States:
  - IDLE: o_dout=0, o_dout_valid=0, o_busy=0, o_load_ready=1.
  - SHIFT: count runs 0..LENGTH-1. o_busy=1. o_load_ready=1 only when count==LENGTH-1.
- Load fires at an edge with i_en=1, i_load_valid=1 and o_load_ready=1.
  - The shift register captures iv_din, count goes to 0 and state goes to SHIFT.
  - o_dout=iv_din[0] from the next cycle: latency 1 cycle from the load edge to the first bit.
- In SHIFT, each edge with i_en=1:
  - If count<LENGTH-1: count increments and o_dout presents the next bit (bit index = count).
  - If count==LENGTH-1 and a load fires: new word, count=0, o_dout=new[0]. There is no idle gap, so word k+1 bit 0 follows word k bit LENGTH-1 directly.
  - If count==LENGTH-1 and no load: go to IDLE, o_dout=0.
- o_dout_valid=1 exactly while o_dout carries bit LENGTH-1 of a word: one cycle per word when i_en stays high.
- If i_en=0:
  - All registers hold, including o_dout/o_dout_valid, which stay high if already high.
  - No load is accepted even when i_load_valid=1 and o_load_ready=1.
  - o_load_ready is not gated by i_en. The source must also see i_en=1 for a transfer.
- iv_din is sampled only on a load edge; changes at other times are ignored.
- i_load_valid may stay high continuously; a word is consumed on each load edge.
- Counter width: $clog2(LENGTH). Count never exceeds LENGTH-1; no wrap other than by reload or IDLE.
- Throughput: one word per LENGTH enabled cycles at saturation.

Optional Feature:
- Macro: SERIALIZER_MSB_FIRST_EN.
- Defined: bits are emitted MSB first (iv_din[LENGTH-1] first, iv_din[0] last, with o_dout_valid on bit 0). The paired receiver must be built to match.
- Undefined (default): LSB first, as above.
- Handshake, latency and o_dout_valid timing are identical in both builds.

Test Plan:
- Reset then idle: hold i_rst=0 for 3 cycles, then release with i_load_valid=0. Required: o_dout=0, o_dout_valid=0, o_busy=0, o_load_ready=1 on every cycle.
- Single word: load 24'hA5C3F0 with i_en=1. Required:
  - Over the next 24 cycles o_dout = bits 0..23 (0,0,0,0,1,1,1,1,...).
  - o_dout_valid=1 only on cycle 24.
  - o_busy falls and o_load_ready=1 afterwards.
- Back-to-back: hold i_load_valid=1 with words 24'h000001 then 24'h800000. Required:
  - 48 contiguous bits with no gap; the first bit is 1, bit 47 is 1, all others 0.
  - o_dout_valid high on cycles 24 and 48.
  - o_load_ready high on the load cycle and on cycle 24.
- Enable stall: during a 24'hFFF000 word, drop i_en for 5 cycles at count 10. Required: o_dout and count frozen; output resumes at bit 11; o_dout_valid is still on the final bit only.
- Mid-word reset: assert i_rst=0 at count 7 of 24'h123456. Required: next cycle o_dout=0, o_dout_valid=0, o_busy=0; a fresh 24'h654321 is then transmitted correctly.
- Loopback: connect to the deserializer with its i_en=1 and send 100 $urandom words. Required: the deserializer's ov_dout equals each sent word on the cycle after o_dout_valid; 0 errors.
